// File: rtl/micro_sequencer_pkg.sv
// Shared constants for the microprogrammed CPU: sequencing codes, opcodes,
// microstore entry addresses and the sequencer state encoding.
package micro_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_NEXT = 2'b00,
    SEQ_MAP  = 2'b01,
    SEQ_BRZ  = 2'b10,
    SEQ_END  = 2'b11
  } seq_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STALL  = 2'b10,
    ST_HALTED = 2'b11
  } seq_state_t;

  localparam logic [7:0] OP_LDAC   = 8'h01;
  localparam logic [7:0] OP_STAC   = 8'h02;
  localparam logic [7:0] OP_MOVACR = 8'h03;
  localparam logic [7:0] OP_SHIFT  = 8'h04;
  localparam logic [7:0] OP_ADD    = 8'h05;
  localparam logic [7:0] OP_INAC   = 8'h06;
  localparam logic [7:0] OP_MVR    = 8'h07;
  localparam logic [7:0] OP_MVTR   = 8'h08;
  localparam logic [7:0] OP_MVACT  = 8'h09;
  localparam logic [7:0] OP_SUB    = 8'h0A;
  localparam logic [7:0] OP_CLAC   = 8'h0B;
  localparam logic [7:0] OP_JUMP   = 8'h0C;
  localparam logic [7:0] OP_JMPZ   = 8'h0D;
  localparam logic [7:0] OP_NOP    = 8'h0E;
  localparam logic [7:0] OP_END    = 8'h0F;
  localparam logic [7:0] OP_LDLDAC = 8'h10;
  localparam logic [7:0] OP_STSTAC = 8'h11;

  localparam logic [7:0] UA_FETCH1  = 8'h00;
  localparam logic [7:0] UA_LDAC1   = 8'h04;
  localparam logic [7:0] UA_STAC1   = 8'h0A;
  localparam logic [7:0] UA_MOVACR1 = 8'h0E;
  localparam logic [7:0] UA_SHIFT1  = 8'h0F;
  localparam logic [7:0] UA_ADD1    = 8'h11;
  localparam logic [7:0] UA_INAC1   = 8'h12;
  localparam logic [7:0] UA_MVR1    = 8'h13;
  localparam logic [7:0] UA_MVTR1   = 8'h14;
  localparam logic [7:0] UA_MVACT1  = 8'h15;
  localparam logic [7:0] UA_SUB1    = 8'h16;
  localparam logic [7:0] UA_CLAC1   = 8'h17;
  localparam logic [7:0] UA_JUMP1   = 8'h18;
  localparam logic [7:0] UA_JMPZ1   = 8'h1B;
  localparam logic [7:0] UA_JMPZN   = 8'h1C;
  localparam logic [7:0] UA_NOP     = 8'h1D;
  localparam logic [7:0] UA_END1    = 8'h1E;
  localparam logic [7:0] UA_LDLDAC1 = 8'h1F;
  localparam logic [7:0] UA_STSTAC1 = 8'h28;
  localparam logic [7:0] UA_JMPZY1  = 8'h9C;

endpackage

// File: rtl/micro_sequencer_opcode_map.sv
// Combinational MAP dispatch: opcode to entry microaddress plus a valid flag
// for opcodes that have a microroutine.
module opcode_map
  import micro_sequencer_pkg::*;
#(
  parameter int AW  = 8,
  parameter int OPW = 8
) (
  input  logic [OPW-1:0] opcode,
  output logic [AW-1:0]  entry,
  output logic           valid
);

  always_comb begin
    entry = AW'(UA_NOP);
    valid = 1'b1;
    case (opcode)
      OPW'(OP_LDAC):   entry = AW'(UA_LDAC1);
      OPW'(OP_STAC):   entry = AW'(UA_STAC1);
      OPW'(OP_MOVACR): entry = AW'(UA_MOVACR1);
      OPW'(OP_SHIFT):  entry = AW'(UA_SHIFT1);
      OPW'(OP_ADD):    entry = AW'(UA_ADD1);
      OPW'(OP_INAC):   entry = AW'(UA_INAC1);
      OPW'(OP_MVR):    entry = AW'(UA_MVR1);
      OPW'(OP_MVTR):   entry = AW'(UA_MVTR1);
      OPW'(OP_MVACT):  entry = AW'(UA_MVACT1);
      OPW'(OP_SUB):    entry = AW'(UA_SUB1);
      OPW'(OP_CLAC):   entry = AW'(UA_CLAC1);
      OPW'(OP_JUMP):   entry = AW'(UA_JUMP1);
      OPW'(OP_JMPZ):   entry = AW'(UA_JMPZ1);
      OPW'(OP_NOP):    entry = AW'(UA_NOP);
      OPW'(OP_END):    entry = AW'(UA_END1);
      OPW'(OP_LDLDAC): entry = AW'(UA_LDLDAC1);
      OPW'(OP_STSTAC): entry = AW'(UA_STSTAC1);
      default: begin
        // unmapped opcodes fall through to the NOP routine
        entry = AW'(UA_NOP);
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microaddress sequencer: picks the next microstore address from the
// sequencing field, with start/halt, memory-stall hold and a cycle counter.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | out of reset, uaddr parked at FETCH1, waiting for start
// ST_RUN    | one microinstruction evaluated per enabled clock
// ST_STALL  | memory busy, uaddr held, microinstruction re-run on exit
// ST_HALTED | END executed, everything held until the next start
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int AW  = 8,
  parameter int OPW = 8,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           start,
  input  logic [1:0]     seq_op,
  input  logic [AW-1:0]  next_addr,
  input  logic [OPW-1:0] opcode,
  input  logic           z_flag,
  input  logic           mem_busy,
  output logic [AW-1:0]  uaddr,
  output logic           running,
  output logic           halted,
  output logic           illegal_op,
  output logic [CW-1:0]  ucycle_cnt
);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] uaddr_q, uaddr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic [AW-1:0] map_entry;
  logic          map_valid;

  opcode_map #(.AW(AW), .OPW(OPW)) u_map (
    .opcode (opcode),
    .entry  (map_entry),
    .valid  (map_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      uaddr_q   <= AW'(UA_FETCH1);
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      uaddr_q   <= uaddr_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    uaddr_d   = uaddr_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        uaddr_d = AW'(UA_FETCH1);
        if (start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          illegal_d = 1'b0;
        end
      end
      ST_RUN: begin
        // a stall defers evaluation; the same microinstruction is re-run later
        if (mem_busy) begin
          state_d = ST_STALL;
        end else begin
          cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
          case (seq_op_t'(seq_op))
            SEQ_NEXT: uaddr_d = next_addr;
            SEQ_MAP: begin
              uaddr_d = map_entry;
              if (!map_valid) illegal_d = 1'b1;
            end
            SEQ_BRZ: uaddr_d = {z_flag, next_addr[AW-2:0]};
            SEQ_END: state_d = ST_HALTED;
            default: uaddr_d = uaddr_q;
          endcase
        end
      end
      ST_STALL: begin
        if (!mem_busy) state_d = ST_RUN;
      end
      ST_HALTED: begin
        if (start) begin
          state_d   = ST_RUN;
          uaddr_d   = AW'(UA_FETCH1);
          cnt_d     = '0;
          illegal_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running    = (state_q == ST_RUN) || (state_q == ST_STALL);
    halted     = (state_q == ST_HALTED);
    uaddr      = uaddr_q;
    ucycle_cnt = cnt_q;
    illegal_op = illegal_q;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with hand-computed expectations.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, start, z_flag, mem_busy;
  logic [1:0]  seq_op;
  logic [7:0]  next_addr, opcode;
  logic [7:0]  uaddr;
  logic        running, halted, illegal_op;
  logic [15:0] ucycle_cnt;

  int errors = 0;
  int checks = 0;

  micro_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .seq_op     (seq_op),
    .next_addr  (next_addr),
    .opcode     (opcode),
    .z_flag     (z_flag),
    .mem_busy   (mem_busy),
    .uaddr      (uaddr),
    .running    (running),
    .halted     (halted),
    .illegal_op (illegal_op),
    .ucycle_cnt (ucycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] na, input logic [7:0] opc, input logic z);
    seq_op = op; next_addr = na; opcode = opc; z_flag = z;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ua, input logic run, input logic hlt,
                         input logic ill, input logic [15:0] cnt);
    chk({tag, ".uaddr"},   {24'h0, uaddr},   {24'h0, ua});
    chk({tag, ".running"}, {31'h0, running}, {31'h0, run});
    chk({tag, ".halted"},  {31'h0, halted},  {31'h0, hlt});
    chk({tag, ".illegal"}, {31'h0, illegal_op}, {31'h0, ill});
    chk({tag, ".cnt"},     {16'h0, ucycle_cnt}, {16'h0, cnt});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; mem_busy = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 1'b0);
    step(); step();
    chk_all("reset", 8'h00, 0, 0, 0, 16'd0);

    rst = 1'b0;
    step();
    chk_all("idle_nostart", 8'h00, 0, 0, 0, 16'd0);

    start = 1'b1; step(); start = 1'b0;
    chk_all("start", 8'h00, 1, 0, 0, 16'd0);

    drive(2'b00, 8'h01, 8'h00, 1'b0); step();
    chk("next1", {24'h0, uaddr}, 32'h01);
    drive(2'b00, 8'h02, 8'h00, 1'b0); step();
    chk("next2", {24'h0, uaddr}, 32'h02);
    drive(2'b00, 8'h03, 8'h00, 1'b0); step();
    chk_all("next3", 8'h03, 1, 0, 0, 16'd3);

    drive(2'b01, 8'h77, 8'h05, 1'b0); step();
    chk_all("map_add", 8'h11, 1, 0, 0, 16'd4);
    drive(2'b01, 8'h77, 8'hFF, 1'b0); step();
    chk_all("map_illegal", 8'h1D, 1, 0, 1, 16'd5);
    drive(2'b01, 8'h77, 8'h0D, 1'b0); step();
    chk_all("map_jmpz_sticky", 8'h1B, 1, 0, 1, 16'd6);
    drive(2'b01, 8'h77, 8'h11, 1'b0); step();
    chk("map_ststac", {24'h0, uaddr}, 32'h28);
    drive(2'b01, 8'h77, 8'h12, 1'b0); step();
    chk("map_just_past_end", {24'h0, uaddr}, 32'h1D);

    drive(2'b10, 8'h1C, 8'h05, 1'b0); step();
    chk("brz_z0", {24'h0, uaddr}, 32'h1C);
    drive(2'b10, 8'h1C, 8'h05, 1'b1); step();
    chk_all("brz_z1", 8'h9C, 1, 0, 1, 16'd10);

    // stall with a pending NEXT to 0x20
    drive(2'b00, 8'h20, 8'h00, 1'b0); mem_busy = 1'b1;
    step(); chk_all("stall1", 8'h9C, 1, 0, 1, 16'd10);
    step(); chk_all("stall2", 8'h9C, 1, 0, 1, 16'd10);
    step(); chk_all("stall3", 8'h9C, 1, 0, 1, 16'd10);
    mem_busy = 1'b0;
    step(); chk_all("stall_exit", 8'h9C, 1, 0, 1, 16'd10);
    step(); chk_all("stall_replay", 8'h20, 1, 0, 1, 16'd11);

    en = 1'b0; drive(2'b00, 8'h33, 8'h00, 1'b0);
    step(); step();
    chk_all("freeze", 8'h20, 1, 0, 1, 16'd11);
    en = 1'b1; step();
    chk_all("resume", 8'h33, 1, 0, 1, 16'd12);

    start = 1'b1; drive(2'b00, 8'h34, 8'h00, 1'b0); step(); start = 1'b0;
    chk_all("start_in_run", 8'h34, 1, 0, 1, 16'd13);

    drive(2'b11, 8'h55, 8'h00, 1'b0); step();
    chk("end.uaddr", {24'h0, uaddr}, 32'h34);
    chk("end.halted", {31'h0, halted}, 32'h1);
    chk("end.running", {31'h0, running}, 32'h0);
    drive(2'b00, 8'h66, 8'h00, 1'b0); step();
    chk("halt_hold.uaddr", {24'h0, uaddr}, 32'h34);
    chk("halt_hold.halted", {31'h0, halted}, 32'h1);
    chk("halt_hold.illegal", {31'h0, illegal_op}, 32'h1);

    start = 1'b1; step(); start = 1'b0;
    chk_all("restart", 8'h00, 1, 0, 0, 16'd0);

    drive(2'b00, 8'h40, 8'h00, 1'b0); step();
    chk_all("pre_stall", 8'h40, 1, 0, 0, 16'd1);
    mem_busy = 1'b1; drive(2'b00, 8'h41, 8'h00, 1'b0); step();
    chk_all("stall_again", 8'h40, 1, 0, 0, 16'd1);
    en = 1'b0; rst = 1'b1; step();
    chk_all("rst_in_stall", 8'h00, 0, 0, 0, 16'd0);
    rst = 1'b0; en = 1'b1; mem_busy = 1'b0;
    step();
    chk_all("idle_after_rst", 8'h00, 0, 0, 0, 16'd0);

    // drive the counter up to 0xFFFE, then across the saturation point
    start = 1'b1; step(); start = 1'b0;
    drive(2'b00, 8'h01, 8'h00, 1'b0);
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    chk("cnt_fffe", {16'h0, ucycle_cnt}, 32'hFFFE);
    step();
    chk("cnt_ffff", {16'h0, ucycle_cnt}, 32'hFFFF);
    step(); step();
    chk("cnt_saturated", {16'h0, ucycle_cnt}, 32'hFFFF);
    chk("cnt_run_uaddr", {24'h0, uaddr}, 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
